ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage_pkg.sv | 27 ++
 rtl/ex_mem_stage_flag_reg.sv | 44 ++++
 rtl/ex_mem_stage.sv | 87 ++++++++
 3 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared opcode encodings and flag bit positions for the EX/MEM pipeline stage.
package ex_mem_stage_pkg;

  typedef enum logic [3:0] {
    OpAdd    = 4'h0,
    OpSub    = 4'h1,
    OpXor    = 4'h2,
    OpRed    = 4'h3,
    OpSll    = 4'h4,
    OpSra    = 4'h5,
    OpRor    = 4'h6,
    OpPaddsb = 4'h7,
    OpLw     = 4'h8,
    OpSw     = 4'h9,
    OpLhb    = 4'hA,
    OpLlb    = 4'hB,
    OpB      = 4'hC,
    OpBr     = 4'hD,
    OpPcs    = 4'hE,
    OpHlt    = 4'hF
  } opcode_e;

  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagV = 1;
  localparam int unsigned FlagN = 0;

endpackage

// File: rtl/ex_mem_stage_flag_reg.sv
// Condition-flag register {Z,V,N}; updates only when en is high, per-opcode field selection.
module flag_reg
  import ex_mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  opcode,
  input  logic [15:0] result,
  input  logic        ovfl,
  output logic [2:0]  flags
);

  logic [2:0] flags_q;
  logic [2:0] flags_d;

  always_comb begin
    flags_d = flags_q;
    if (en) begin
      case (opcode)
        OpAdd, OpSub: begin
          flags_d[FlagZ] = (result == 16'h0000);
          flags_d[FlagV] = ovfl;
          flags_d[FlagN] = result[15];
        end
        OpXor, OpSll, OpSra, OpRor: begin
          flags_d[FlagZ] = (result == 16'h0000);
        end
        default: flags_d = flags_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with flush/stall control, condition flags and sticky halt.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] ex_alu_result,
  input  logic        ex_alu_ovfl,
  input  logic [15:0] ex_store_data,
  input  logic [3:0]  ex_dst_reg,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  output logic        mem_valid,
  output logic [3:0]  mem_opcode,
  output logic [15:0] mem_alu_result,
  output logic [15:0] mem_store_data,
  output logic [3:0]  mem_dst_reg,
  output logic        mem_reg_write,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic [2:0]  flags,
  output logic        fwd_valid,
  output logic        halted
);

  logic halted_q;
  logic load;
  logic take;

  // A real instruction enters only on a load cycle before the pipeline has halted.
  assign load = !flush && !stall;
  assign take = load && ex_valid && !halted_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_opcode     <= 4'h0;
      mem_alu_result <= 16'h0000;
      mem_store_data <= 16'h0000;
      mem_dst_reg    <= 4'h0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      halted_q       <= 1'b0;
    end else if (flush || (load && !take)) begin
      mem_valid      <= 1'b0;
      mem_opcode     <= 4'h0;
      mem_alu_result <= 16'h0000;
      mem_store_data <= 16'h0000;
      mem_dst_reg    <= 4'h0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
    end else if (take) begin
      mem_valid      <= 1'b1;
      mem_opcode     <= ex_opcode;
      mem_alu_result <= ex_alu_result;
      mem_store_data <= ex_store_data;
      mem_dst_reg    <= ex_dst_reg;
      mem_reg_write  <= ex_reg_write;
      mem_mem_read   <= ex_mem_read;
      mem_mem_write  <= ex_mem_write;
      if (ex_opcode == OpHlt) begin
        halted_q <= 1'b1;
      end
    end
  end

  flag_reg u_flag_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (take),
    .opcode (ex_opcode),
    .result (ex_alu_result),
    .ovfl   (ex_alu_ovfl),
    .flags  (flags)
  );

  assign fwd_valid = mem_valid && mem_reg_write && (mem_dst_reg != 4'h0);
  assign halted    = halted_q;

endmodule
